// File: rtl/d_mem_wbuf_if.sv
// Data-memory port between the access unit (master) and the memory (slave).
// The request side is held by the master until the memory answers with mem_ready.
interface d_mem_wbuf_if #(
  parameter int XLEN = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/d_mem_wbuf.sv
// Data-memory access unit: posted stores go into a FIFO write buffer and drain in
// the background; loads bypass the buffer unless an entry holds the same word.
module d_mem_wbuf #(
  parameter int XLEN       = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [XLEN-1:0] i_addr,
  input  logic [2:0]      i_f3,
  input  logic            i_wr_en,
  input  logic            i_rd_en,
  input  logic            i_fence,
  output logic [XLEN-1:0] o_rd,
  output logic            o_stall,
  output logic            o_ex_ld,
  output logic            o_ex_st,
  output logic            o_wbuf_empty,
  d_mem_wbuf_if.master    mem
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW   = $clog2(WBUF_DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ST_BUSY = 2'd1;
  localparam logic [1:0] S_LD_BUSY = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WBUF_DEPTH-1:0] vld_q, vld_d;
  logic [XLEN-1:0] addr_q [WBUF_DEPTH];
  logic [XLEN-1:0] data_q [WBUF_DEPTH];
  logic [NB-1:0]   bemem_q [WBUF_DEPTH];

  logic            mwe_q;
  logic [XLEN-1:0] maddr_q, mwdata_q;
  logic [NB-1:0]   mbe_q;
  logic [OFFW-1:0] ld_off_q;
  logic [2:0]      ld_f3_q;

  logic [OFFW-1:0] off;
  logic [XLEN-1:0] aaddr, wd;
  logic [3:0]      size_m1;
  logic [7:0]      mask8;
  logic [15:0]     be_w;
  logic [NB-1:0]   be;
  logic            illegal, misal, ex, ld_req, exc;
  logic            full, enq, pop, ld_go, hazard, ld_pend;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request decode: lane offset, size, byte enables, shifted store data.
  always_comb begin
    off   = i_addr[OFFW-1:0];
    aaddr = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    case (i_f3[1:0])
      2'b00:   begin size_m1 = 4'd0; mask8 = 8'h01; end
      2'b01:   begin size_m1 = 4'd1; mask8 = 8'h03; end
      2'b10:   begin size_m1 = 4'd3; mask8 = 8'h0F; end
      default: begin size_m1 = 4'd7; mask8 = 8'hFF; end
    endcase
    illegal = (i_f3 == 3'b111) ||
              ((XLEN == 32) && ((i_f3 == 3'b011) || (i_f3 == 3'b110)));
    misal   = (({{(4-OFFW){1'b0}}, off} & size_m1) != 4'd0);
    ex      = illegal | misal;
    be_w    = {8'b0, mask8} << off;
    be      = be_w[NB-1:0];
    wd      = i_wr_data << {off, 3'b000};
  end

  // A simultaneous store wins; the load half of the request is dropped.
  assign ld_req  = i_rd_en & ~i_wr_en;
  assign o_ex_ld = ld_req & ex;
  assign o_ex_st = i_wr_en & ex;
  assign exc     = o_ex_ld | o_ex_st;

  // The in-flight store stays valid at the head until popped, so one scan covers both.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++)
      if (vld_q[i] && (addr_q[i] == aaddr)) hazard = 1'b1;
  end

  assign full  = (count_q == CW'(WBUF_DEPTH));
  assign enq   = i_wr_en & ~ex & ~full;
  assign pop   = (state_q == S_ST_BUSY) & mem.mem_ready;
  assign ld_go = (state_q == S_IDLE) & ld_req & ~ex & ~hazard;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_go)                 state_d = S_LD_BUSY;
        else if (count_q != '0)    state_d = S_ST_BUSY;
      end
      S_ST_BUSY: if (mem.mem_ready) state_d = S_IDLE;
      S_LD_BUSY: if (mem.mem_ready) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    head_d = pop ? inc(head_q) : head_q;
    tail_d = enq ? inc(tail_q) : tail_q;
    vld_d  = vld_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (enq) vld_d[tail_q] = 1'b1;
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      ld_off_q <= '0;
      ld_f3_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      // Memory-side fields are latched only on entry to a busy state.
      if (ld_go) begin
        mwe_q    <= 1'b0;
        maddr_q  <= aaddr;
        mwdata_q <= '0;
        mbe_q    <= be;
        ld_off_q <= off;
        ld_f3_q  <= i_f3;
      end else if ((state_q == S_IDLE) && (count_q != '0)) begin
        mwe_q    <= 1'b1;
        maddr_q  <= addr_q[head_q];
        mwdata_q <= data_q[head_q];
        mbe_q    <= bemem_q[head_q];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      addr_q[tail_q]  <= aaddr;
      data_q[tail_q]  <= wd;
      bemem_q[tail_q] <= be;
    end
  end

  assign mem.mem_req   = (state_q != S_IDLE);
  assign mem.mem_we    = mwe_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;
  assign mem.mem_be    = mbe_q;

  logic [XLEN-1:0] sh;
  logic [63:0]     sh64, r64;
  always_comb begin
    sh   = mem.mem_rdata >> {ld_off_q, 3'b000};
    sh64 = 64'(sh);
    case (ld_f3_q)
      3'b000:  r64 = {{56{sh64[7]}},  sh64[7:0]};
      3'b001:  r64 = {{48{sh64[15]}}, sh64[15:0]};
      3'b010:  r64 = {{32{sh64[31]}}, sh64[31:0]};
      3'b100:  r64 = {56'b0, sh64[7:0]};
      3'b101:  r64 = {48'b0, sh64[15:0]};
      3'b110:  r64 = {32'b0, sh64[31:0]};
      default: r64 = sh64;
    endcase
    o_rd = r64[XLEN-1:0];
  end

  assign o_wbuf_empty = (count_q == '0) && (state_q != S_ST_BUSY);
  assign ld_pend      = ld_req & ~((state_q == S_LD_BUSY) & mem.mem_ready);
  assign o_stall      = ~exc & (ld_pend | (i_wr_en & full) | (i_fence & ~o_wbuf_empty));
endmodule

// File: tb/tb_d_mem_wbuf.sv
// Directed bench for d_mem_wbuf at XLEN=32 and XLEN=64; a scoreboard queue holds the
// memory transactions (and load results) each request is expected to produce, in order.
module tb_d_mem_wbuf;
  logic        i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        rst_n, sel64, wr_en, rd_en, fence, mem_ready;
  logic [63:0] wr_data, addr, mem_rdata;
  logic [2:0]  f3;

  d_mem_wbuf_if #(.XLEN(32)) m32 ();
  d_mem_wbuf_if #(.XLEN(64)) m64 ();
  assign m32.mem_ready = mem_ready & ~sel64;
  assign m32.mem_rdata = mem_rdata[31:0];
  assign m64.mem_ready = mem_ready & sel64;
  assign m64.mem_rdata = mem_rdata;

  logic [31:0] rd32;
  logic [63:0] rd64;
  logic st32, exl32, exs32, emp32, st64, exl64, exs64, emp64;

  d_mem_wbuf #(.XLEN(32), .WBUF_DEPTH(4)) u32 (
    .i_clk(i_clk), .i_rst(rst_n), .i_wr_data(wr_data[31:0]), .i_addr(addr[31:0]),
    .i_f3(f3), .i_wr_en(wr_en & ~sel64), .i_rd_en(rd_en & ~sel64),
    .i_fence(fence & ~sel64), .o_rd(rd32), .o_stall(st32), .o_ex_ld(exl32),
    .o_ex_st(exs32), .o_wbuf_empty(emp32), .mem(m32));

  d_mem_wbuf #(.XLEN(64), .WBUF_DEPTH(4)) u64 (
    .i_clk(i_clk), .i_rst(rst_n), .i_wr_data(wr_data), .i_addr(addr),
    .i_f3(f3), .i_wr_en(wr_en & sel64), .i_rd_en(rd_en & sel64),
    .i_fence(fence & sel64), .o_rd(rd64), .o_stall(st64), .o_ex_ld(exl64),
    .o_ex_st(exs64), .o_wbuf_empty(emp64), .mem(m64));

  wire [63:0] o_rd   = sel64 ? rd64 : {32'b0, rd32};
  wire        stall  = sel64 ? st64 : st32;
  wire        ex_ld  = sel64 ? exl64 : exl32;
  wire        ex_st  = sel64 ? exs64 : exs32;
  wire        empty  = sel64 ? emp64 : emp32;
  wire        req    = sel64 ? m64.mem_req : m32.mem_req;
  wire        we     = sel64 ? m64.mem_we : m32.mem_we;
  wire [63:0] maddr  = sel64 ? m64.mem_addr : {32'b0, m32.mem_addr};
  wire [63:0] mwdata = sel64 ? m64.mem_wdata : {32'b0, m32.mem_wdata};
  wire [7:0]  mbe    = sel64 ? m64.mem_be : {4'b0, m32.mem_be};

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd;
    logic [7:0]  be;
  } txn_t;
  txn_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'b0, obs}, {63'b0, exp});
  endtask

  task automatic idle();
    @(negedge i_clk);
    wr_en = 1'b0; rd_en = 1'b0; fence = 1'b0;
    #1;
  endtask

  // Holds the store request; the caller ends it with idle() or another request.
  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] fn,
                       input logic [63:0] ea, input logic [63:0] ewd, input logic [7:0] ebe);
    @(negedge i_clk);
    wr_en = 1'b1; rd_en = 1'b0; addr = a; wr_data = d; f3 = fn;
    #1;
    chk1("st_nostall", stall, 1'b0);
    sbq.push_back('{we: 1'b1, addr: ea, wdata: ewd, rd: 64'd0, be: ebe});
  endtask

  task automatic load(input logic [63:0] a, input logic [2:0] fn, input logic [63:0] ea,
                      input logic [7:0] ebe, input logic [63:0] erd, input bit front);
    @(negedge i_clk);
    wr_en = 1'b0; rd_en = 1'b1; addr = a; f3 = fn;
    #1;
    chk1("ld_stall", stall, 1'b1);
    if (front) sbq.push_front('{we: 1'b0, addr: ea, wdata: 64'd0, rd: erd, be: ebe});
    else       sbq.push_back('{we: 1'b0, addr: ea, wdata: 64'd0, rd: erd, be: ebe});
  endtask

  // Memory model: wait for a request, check it against the scoreboard, answer with ready.
  task automatic serve(input logic [63:0] rdata);
    txn_t e;
    int n = 0;
    while (req !== 1'b1 && n < 40) begin
      @(negedge i_clk); #1; n++;
    end
    chk1("mem_req_seen", req, 1'b1);
    chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk1("mem_we", we, e.we);
      chk("mem_addr", maddr, e.addr);
      chk("mem_be", {56'b0, mbe}, {56'b0, e.be});
      if (e.we) chk("mem_wdata", mwdata, e.wdata);
      mem_rdata = rdata; mem_ready = 1'b1;
      #1;
      if (!e.we) begin
        chk("o_rd", o_rd, e.rd);
        chk1("ld_done_nostall", stall, 1'b0);
      end
      @(negedge i_clk);
      mem_ready = 1'b0;
      if (!e.we) rd_en = 1'b0;
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel64 = 1'b0; wr_en = 1'b0; rd_en = 1'b0; fence = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0; wr_data = '0; addr = '0; f3 = 3'b000;
    repeat (2) @(negedge i_clk);
    #1;
    chk1("rst_req", req, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_ex_ld", ex_ld, 1'b0);
    chk1("rst_ex_st", ex_st, 1'b0);
    chk("rst_addr", maddr, 64'd0);
    @(negedge i_clk); rst_n = 1'b1;

    // Fill the buffer with memory held off, then overflow by one.
    for (int i = 0; i < 4; i++)
      store(64'h100 + 64'(4*i), 64'hA0 + 64'(i), 3'b010,
            64'h100 + 64'(4*i), 64'hA0 + 64'(i), 8'h0F);
    @(negedge i_clk);
    addr = 64'h110; wr_data = 64'hA4;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("full_stall", stall, 1'b1);
      @(negedge i_clk); #1;
    end
    serve(64'd0);
    chk1("full_release", stall, 1'b0);
    sbq.push_back('{we: 1'b1, addr: 64'h110, wdata: 64'hA4, rd: 64'd0, be: 8'h0F});
    idle();
    for (int i = 0; i < 4; i++) serve(64'd0);
    repeat (3) idle();
    chk1("drain_empty", empty, 1'b1);
    chk1("drain_noreq", req, 1'b0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    // Sub-word lanes and extension.
    store(64'h203, 64'hAB, 3'b000, 64'h200, 64'hAB000000, 8'h08);
    idle(); serve(64'd0);
    load(64'h203, 3'b000, 64'h200, 8'h08, 64'hFFFFFF80, 1'b0); serve(64'h80000000);
    load(64'h203, 3'b100, 64'h200, 8'h08, 64'h00000080, 1'b0); serve(64'h80000000);
    load(64'h102, 3'b101, 64'h100, 8'h0C, 64'h0000BEEF, 1'b0); serve(64'hBEEF0000);
    load(64'h102, 3'b001, 64'h100, 8'h0C, 64'hFFFF8001, 1'b0); serve(64'h80010000);

    // Same-word load must wait for the buffered store to complete.
    store(64'h40, 64'h11223344, 3'b010, 64'h40, 64'h11223344, 8'h0F);
    load(64'h40, 3'b010, 64'h40, 8'h0F, 64'h55667788, 1'b0);
    serve(64'd0);
    chk1("hz_still_stall", stall, 1'b1);
    serve(64'h55667788);

    // Different-word load overtakes the buffered store, so it is expected first.
    store(64'h40, 64'h99, 3'b010, 64'h40, 64'h99, 8'h0F);
    load(64'h80, 3'b010, 64'h80, 8'h0F, 64'hCAFEF00D, 1'b1);
    serve(64'hCAFEF00D);
    idle(); serve(64'd0);

    // Exceptions.
    @(negedge i_clk); rd_en = 1'b1; addr = 64'h101; f3 = 3'b001; #1;
    chk1("lh_mis_ex_ld", ex_ld, 1'b1);
    chk1("lh_mis_stall", stall, 1'b0);
    chk1("lh_mis_ex_st", ex_st, 1'b0);
    @(negedge i_clk); #1;
    chk1("lh_mis_noreq", req, 1'b0);
    @(negedge i_clk); addr = 64'h0; f3 = 3'b011; #1;
    chk1("ld32_illegal", ex_ld, 1'b1);
    idle();
    @(negedge i_clk); wr_en = 1'b1; addr = 64'h102; f3 = 3'b010; wr_data = 64'h5; #1;
    chk1("sw_mis_ex_st", ex_st, 1'b1);
    chk1("sw_mis_stall", stall, 1'b0);
    @(negedge i_clk); #1;
    chk1("sw_mis_empty", empty, 1'b1);
    idle(); idle();
    chk1("sw_mis_noreq", req, 1'b0);

    // Fence holds until the buffer has fully drained.
    for (int i = 0; i < 3; i++)
      store(64'h300 + 64'(4*i), 64'hF0 + 64'(i), 3'b010,
            64'h300 + 64'(4*i), 64'hF0 + 64'(i), 8'h0F);
    @(negedge i_clk); wr_en = 1'b0; fence = 1'b1; #1;
    chk1("fence_stall", stall, 1'b1);
    serve(64'd0); chk1("fence_stall1", stall, 1'b1);
    serve(64'd0); chk1("fence_stall2", stall, 1'b1);
    serve(64'd0);
    chk1("fence_empty", empty, 1'b1);
    chk1("fence_release", stall, 1'b0);
    idle();

    // Reset while a store is in flight discards it.
    store(64'h500, 64'h1, 3'b010, 64'h500, 64'h1, 8'h0F);
    idle();
    for (int n = 0; n < 10 && req !== 1'b1; n++) begin @(negedge i_clk); #1; end
    chk1("rst_busy_req", req, 1'b1);
    @(negedge i_clk); rst_n = 1'b0; #1;
    @(negedge i_clk); #1;
    chk1("rst_busy_noreq", req, 1'b0);
    chk1("rst_busy_empty", empty, 1'b1);
    sbq.delete();
    @(negedge i_clk); rst_n = 1'b1;
    idle(); idle();
    chk1("rst_discard", req, 1'b0);

    // XLEN=64 instance.
    @(negedge i_clk); sel64 = 1'b1; #1;
    store(64'h8, 64'h0123456789ABCDEF, 3'b011, 64'h8, 64'h0123456789ABCDEF, 8'hFF);
    idle(); serve(64'd0);
    store(64'h7, 64'h5A, 3'b000, 64'h0, 64'h5A00000000000000, 8'h80);
    idle(); serve(64'd0);
    load(64'hC, 3'b110, 64'h8, 8'hF0, 64'h0000000080000000, 1'b0);
    serve(64'h8000000000000000);
    load(64'hC, 3'b010, 64'h8, 8'hF0, 64'hFFFFFFFF80000000, 1'b0);
    serve(64'h8000000000000000);
    @(negedge i_clk); rd_en = 1'b1; addr = 64'h4; f3 = 3'b011; #1;
    chk1("ld64_mis_ex_ld", ex_ld, 1'b1);
    chk1("ld64_mis_stall", stall, 1'b0);
    idle(); idle();
    chk1("ld64_mis_noreq", req, 1'b0);
    chk("sb_final", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/d_mem_wbuf.md
# d_mem_wbuf

Parametrised data-memory access unit with a posted-store write buffer. It sits between the execute/memory stage and the data-memory port. Stores retire to a FIFO without stalling the pipeline, and loads bypass non-conflicting buffered stores. It supports XLEN of 32 or 64, including LD/SD/LWU on 64-bit, and keeps the alignment-exception behaviour of the existing data path.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64. NB = XLEN/8 byte lanes.
- WBUF_DEPTH, 4, write-buffer entries; power of two, >= 1.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_wr_data  in  XLEN  store data, LSB-justified.
- i_addr  in  XLEN  byte address.
- i_f3  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- i_wr_en / i_rd_en  in  1  store / load request, held until o_stall low.
- i_fence  in  1  fence request: hold pipeline until buffer drained.
- o_rd  out  XLEN  load result, sign/zero extended.
- o_stall  out  1  pipeline hold.
- o_ex_ld / o_ex_st  out  1  load / store address-misaligned or illegal-size exception.
- o_wbuf_empty  out  1  buffer empty and no store in flight.
- o_mem_req  out  1  memory request, held until i_mem_ready.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  XLEN  address aligned to NB: low log2(NB) bits are 0.
- o_mem_wdata  out  XLEN  lane-shifted write data.
- o_mem_be  out  NB  byte enables.
- i_mem_ready  in  1  transaction complete this cycle.
- i_mem_rdata  in  XLEN  read data, valid when i_mem_ready is high during a read.

## Operation
- Lane/byte-enable generation:
  - Offset = i_addr[log2(NB)-1:0].
  - Access size is 1, 2, 4 or 8 bytes. The byte-enable mask is 2^size-1 shifted left by the offset.
  - Write data is shifted left by 8·offset. Read data is shifted right by 8·offset, then extended per f3.
- Exceptions (combinational, same cycle):
  - Raised when the offset is not a multiple of the size.
  - Raised when f3 is 011/110 while XLEN=32, or f3 is 111.
  - o_ex_ld is gated by i_rd_en; o_ex_st is gated by i_wr_en.
  - On an exception, nothing is enqueued or issued and o_stall=0.
- Write buffer:
  - FIFO of {aligned addr, wdata, be}, with head/tail pointers and a count.
  - A store is enqueued in a cycle where i_wr_en is high, there is no exception and count<WBUF_DEPTH. o_stall=0 that cycle.
  - If the buffer is full, o_stall=1 and there is no enqueue, even if the head drains at that same edge.
- Load hazard: a load conflicts if any valid entry, or the store in flight, has the same aligned address. A conflicting load waits until no conflicting entry remains. There is no forwarding.
- FSM states IDLE, ST_BUSY, LD_BUSY:
  - From IDLE, an eligible load (i_rd_en, no exception, no hazard) has priority and goes to LD_BUSY.
  - Otherwise, from IDLE, count>0 goes to ST_BUSY, which issues the head entry.
  - From ST_BUSY, i_mem_ready pops the head and returns to IDLE.
  - From LD_BUSY, i_mem_ready returns to IDLE. o_rd is valid and o_stall=0 in that same cycle.
  - o_mem_req=1 exactly while in ST_BUSY or LD_BUSY. Address, data and byte enables are registered on entry and stay stable until ready.
- o_stall = (load not yet completed) OR (store while full) OR (i_fence and !o_wbuf_empty); forced 0 on exception.
- Simultaneous i_rd_en and i_wr_en: treated as a store; the load is ignored.
- Reset:
  - Pointers and count go to 0; state goes to IDLE; pending stores are discarded.
  - All registered memory-side outputs go to 0; o_wbuf_empty=1.
  - With requests low: o_stall=0, o_ex_*=0. o_rd follows i_mem_rdata through extension, don't-care.

## Timing
- Store (not full): 0 stall cycles. It drains later, taking at least 1 cycle of o_mem_req.
- Load, memory idle and no hazard:
  - Cycle 0: i_rd_en with the FSM in IDLE, stall=1.
  - Cycle 1 onward: o_mem_req=1.
  - Completes in the first cycle i_mem_ready=1. Minimum latency is 1 stall cycle.
- Load arriving while ST_BUSY: waits for that drain to complete, then issues from IDLE on the next cycle.
- Back-to-back drains: one IDLE cycle between transactions.
- Count update on simultaneous enqueue and pop: count is unchanged and the pointers both advance.
- Pointers wrap modulo WBUF_DEPTH.

## Test plan
- XLEN=32, DEPTH=4:
  - 4 back-to-back SW to 0x100..0x10C with i_mem_ready low → no stall, and count=4.
  - A 5th SW → o_stall=1 until the first ready.
  - The drain order on o_mem_addr is 0x100, 0x104, 0x108, 0x10C.
- SB 0xAB to 0x203 → o_mem_be=1000, o_mem_wdata=0xAB000000.
- LB from 0x203 with rdata 0x80000000 → o_rd=0xFFFFFF80; LBU → 0x00000080.
- Hazard:
  - With SW 0x11223344 @0x40 buffered, an LW @0x40 stalls until the store completes, then reads memory.
  - An LW @0x80 issues before the buffered store drains.
- Exceptions: LH @0x101 → o_ex_ld=1, o_stall=0, o_mem_req stays 0. SW @0x102 → o_ex_st=1, nothing enqueued.
- XLEN=64:
  - SD 0x0123456789ABCDEF @0x8 → be=0xFF.
  - LWU @0xC with rdata 0x8000000000000000 → o_rd=0x0000000080000000.
  - LD @0x4 → o_ex_ld=1.
- Fence: 3 stores buffered, assert i_fence → o_stall=1 until o_wbuf_empty=1.
- Reset during ST_BUSY → next cycle o_mem_req=0 and o_wbuf_empty=1.
